branch_pc_unit: RTL and testbench
=================================

BRANCH_PC_UNIT -- requirements
Module: branch_pc_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 The block SHALL have parameter TRAP_VEC, default 32'h0000_0100, meaning the PC value loaded on a misaligned-target trap.
REQ-003 The block SHALL have port i_clk  input  1  meaning the single clock, all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  meaning reset, synchronous and active-low.
REQ-005 The block SHALL have port i_stall  input  1  meaning hold the PC and all counters this cycle.
REQ-006 The block SHALL have ports i_is_branch, i_is_jal and i_is_jalr  input  1 each  meaning the instruction class, at most one high.
REQ-007 The block SHALL have port i_funct3  input  3  meaning the branch condition code.
REQ-008 The block SHALL have ports i_br_less and i_br_equal  input  1 each  meaning the result of the 32-bit operand comparator.
REQ-009 The block SHALL have port i_target  input  32  meaning the computed branch or jump target.
REQ-010 The block SHALL have port i_trap_clr  input  1  meaning acknowledge and leave trap.
REQ-011 The block SHALL have output ports as follows.
- o_pc  output  32  meaning the current PC.
- o_pc_four  output  32  meaning o_pc + 4.
- o_br_un  output  1  meaning the unsigned-compare select sent to the comparator.
- o_taken  output  1  meaning redirect this cycle.
- o_trap  output  1  meaning the block is in trap.
- o_taken_cnt  output  16  meaning the number of redirects.

Function
REQ-012 o_br_un SHALL equal i_funct3[1], combinationally.
REQ-013 The branch condition SHALL be decoded from i_funct3 as follows: 000 -> equal; 001 -> !equal; 100 and 110 -> less; 101 and 111 -> !less; 010 and 011 -> false.
REQ-014 o_taken SHALL equal (i_is_jal | i_is_jalr | (i_is_branch & cond)) and SHALL be forced low when the state is TRAP.
REQ-015 The effective target SHALL be i_target with bit 0 cleared for JALR, and i_target unchanged otherwise.
REQ-016 A target SHALL be misaligned when bits [1:0] of the effective target are nonzero.
REQ-017 The state machine SHALL have two states, RUN and TRAP; o_trap SHALL be 1 exactly in TRAP.
REQ-018 In RUN, on each clock edge, the first matching rule SHALL apply.
- When i_stall=1: PC and counter hold.
- When taken and the target is misaligned: PC<=TRAP_VEC and the state goes to TRAP, with no count.
- When taken: PC<=effective target and the counter increments.
- Otherwise: PC<=PC+4.
REQ-019 In TRAP, PC SHALL hold TRAP_VEC regardless of i_stall; i_trap_clr=1 SHALL move the state to RUN with PC unchanged, so the next RUN edge advances from TRAP_VEC.
REQ-020 i_trap_clr SHALL be ignored in RUN.
REQ-021 PC+4 SHALL wrap modulo 2^32, so 32'hFFFF_FFFC is followed by 32'h0000_0000.
REQ-022 o_taken_cnt SHALL saturate at 16'hFFFF.
REQ-023 The PC update latency SHALL be one cycle: a redirect decided in cycle N SHALL appear on o_pc in cycle N+1.

Reset
REQ-024 When i_rst_n=0 at a clock edge, the block SHALL set o_pc=RESET_PC, set the state to RUN, set o_taken_cnt=0 and drive o_trap=0, overriding stall, trap and any in-flight redirect.
REQ-025 After reset, o_pc_four SHALL read RESET_PC+4, and o_taken and o_br_un SHALL follow their combinational inputs.

Structure
REQ-026 A package branch_pkg SHALL hold the funct3 constants (BEQ, BNE, BLT, BGE, BLTU, BGEU) and the state enum {RUN, TRAP}.
REQ-027 The condition decode SHALL be a combinational sub-module br_cond, with inputs funct3, less and equal, and output cond.

Verification
REQ-028 The bench SHALL cover this scenario: reset release, then 3 cycles with no branch -> o_pc = 0x0, 0x4, 0x8, 0xC and o_taken_cnt=0.
REQ-029 The bench SHALL cover this scenario: BLT (funct3=100) with less=1 and target 0x40 -> o_br_un=0, o_taken=1, next o_pc=0x40 and cnt=1; the same with less=0 -> PC+4.
REQ-030 The bench SHALL cover this scenario: JALR with target 0x81 -> next o_pc=0x80; then JAL with target 0x82 -> next o_pc=TRAP_VEC, o_trap=1, o_taken low while in trap, cnt unchanged.
REQ-031 The bench SHALL cover this scenario: in TRAP, i_stall=1 for 2 cycles with i_trap_clr=0 -> PC stays 0x100; then i_trap_clr=1 -> o_trap=0 and the next edges give 0x100 then 0x104.
REQ-032 The bench SHALL cover this scenario: i_stall=1 during a taken BEQ -> PC and cnt hold; PC forced to 0xFFFF_FFFC with no branch -> next o_pc=0x0.
REQ-033 The bench SHALL cover this scenario: i_rst_n=0 in TRAP with cnt=5 -> next cycle o_pc=RESET_PC, o_trap=0, cnt=0; also 65536 taken jumps -> cnt stays 0xFFFF.

Source files
------------

// File: rtl/branch_pkg.sv
// Shared constants and types for the branch / PC unit: funct3 branch codes
// and the RUN/TRAP state encoding.
package branch_pkg;

   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;

   localparam logic [15:0] CNT_MAX = 16'hFFFF;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic {
      RUN  = 1'b0,
      TRAP = 1'b1
   } state_t;

endpackage

// File: rtl/br_cond.sv
// Branch condition decode: maps funct3 plus the comparator flags onto a
// single taken/not-taken condition. Purely combinational.
module br_cond
   import branch_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       less,
   input  logic       equal,
   output logic       cond
);

   always_comb begin
      cond = 1'b0;
      case (funct3)
         BEQ:         cond = equal;
         BNE:         cond = ~equal;
         BLT, BLTU:   cond = less;
         BGE, BGEU:   cond = ~less;
         // 010 and 011 are not branch encodings and never redirect
         default:     cond = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter with branch/jump redirect, misaligned-target trap state,
// and a saturating count of redirects.
module branch_pc_unit
   import branch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_stall,
   input  logic        i_is_branch,
   input  logic        i_is_jal,
   input  logic        i_is_jalr,
   input  logic [2:0]  i_funct3,
   input  logic        i_br_less,
   input  logic        i_br_equal,
   input  logic [31:0] i_target,
   input  logic        i_trap_clr,
   output logic [31:0] o_pc,
   output logic [31:0] o_pc_four,
   output logic        o_br_un,
   output logic        o_taken,
   output logic        o_trap,
   output logic [15:0] o_taken_cnt
);

   state_t      state;
   logic [31:0] pc;
   logic [15:0] cnt;
   logic        cond;
   logic        redirect;
   logic [31:0] eff_target;
   logic        misaligned;

   br_cond u_br_cond (
      .funct3 (i_funct3),
      .less   (i_br_less),
      .equal  (i_br_equal),
      .cond   (cond)
   );

   assign redirect   = i_is_jal | i_is_jalr | (i_is_branch & cond);
   // JALR drops bit 0 of the target before the alignment test
   assign eff_target = i_is_jalr ? {i_target[31:1], 1'b0} : i_target;
   assign misaligned = |eff_target[1:0];

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= RUN;
         pc    <= RESET_PC;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: begin
               if (i_stall) begin
                  pc  <= pc;
                  cnt <= cnt;
               end else if (redirect && misaligned) begin
                  pc    <= TRAP_VEC;
                  state <= TRAP;
               end else if (redirect) begin
                  pc <= eff_target;
                  if (cnt != CNT_MAX) begin
                     cnt <= cnt + 16'd1;
                  end
               end else begin
                  pc <= pc + PC_STEP;
               end
            end
            TRAP: begin
               // PC is pinned to the vector; leaving trap does not advance it
               pc <= TRAP_VEC;
               if (i_trap_clr) begin
                  state <= RUN;
               end
            end
            default: begin
               state <= RUN;
               pc    <= RESET_PC;
            end
         endcase
      end
   end

   assign o_pc        = pc;
   assign o_pc_four   = pc + PC_STEP;
   assign o_br_un     = i_funct3[1];
   assign o_taken     = redirect & (state == RUN);
   assign o_trap      = (state == TRAP);
   assign o_taken_cnt = cnt;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed bench for branch_pc_unit: a cycle-level reference model checked
// every cycle, plus hand-computed literal expectations along the way.
module tb_branch_pc_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;

   logic        clk;
   logic        rst_n;
   logic        stall;
   logic        is_branch;
   logic        is_jal;
   logic        is_jalr;
   logic [2:0]  funct3;
   logic        br_less;
   logic        br_equal;
   logic [31:0] target;
   logic        trap_clr;
   logic [31:0] pc;
   logic [31:0] pc_four;
   logic        br_un;
   logic        taken;
   logic        trap;
   logic [15:0] taken_cnt;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   branch_pc_unit #(
      .RESET_PC (RESET_PC),
      .TRAP_VEC (TRAP_VEC)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_stall     (stall),
      .i_is_branch (is_branch),
      .i_is_jal    (is_jal),
      .i_is_jalr   (is_jalr),
      .i_funct3    (funct3),
      .i_br_less   (br_less),
      .i_br_equal  (br_equal),
      .i_target    (target),
      .i_trap_clr  (trap_clr),
      .o_pc        (pc),
      .o_pc_four   (pc_four),
      .o_br_un     (br_un),
      .o_taken     (taken),
      .o_trap      (trap),
      .o_taken_cnt (taken_cnt)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         if (errors <= 40)
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model
   int unsigned m_pc;
   bit          m_trap;
   int unsigned m_cnt;

   function automatic bit m_cond(input logic [2:0] f, input logic lt, input logic eq);
      case (f)
         3'd0:       return eq;
         3'd1:       return !eq;
         3'd4, 3'd6: return lt;
         3'd5, 3'd7: return !lt;
         default:    return 1'b0;
      endcase
   endfunction

   function automatic bit m_redirect();
      return is_jal || is_jalr || (is_branch && m_cond(funct3, br_less, br_equal));
   endfunction

   function automatic int unsigned m_eff();
      int unsigned t;
      t = target;
      if (is_jalr) t = t - (t % 2);
      return t;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_pc   = RESET_PC;
         m_trap = 0;
         m_cnt  = 0;
      end else if (m_trap) begin
         m_pc = TRAP_VEC;
         if (trap_clr) m_trap = 0;
      end else if (!stall) begin
         if (m_redirect()) begin
            if (m_eff() % 4 != 0) begin
               m_pc   = TRAP_VEC;
               m_trap = 1;
            end else begin
               m_pc = m_eff();
               if (m_cnt < 65535) m_cnt = m_cnt + 1;
            end
         end else begin
            m_pc = m_pc + 4;
         end
      end
   end

   // per-cycle compare against the model
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_pc", pc, m_pc);
         chk("model_pc_four", pc_four, m_pc + 4);
         chk("model_trap", {31'd0, trap}, {31'd0, m_trap});
         chk("model_cnt", {16'd0, taken_cnt}, m_cnt);
         chk("model_taken", {31'd0, taken}, {31'd0, (!m_trap && m_redirect())});
         chk("model_br_un", {31'd0, br_un}, {31'd0, funct3[1]});
      end
   end

   // driver tasks
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      stall     = 0;
      is_branch = 0;
      is_jal    = 0;
      is_jalr   = 0;
      funct3    = 3'b010;
      br_less   = 0;
      br_equal  = 0;
      target    = 32'h0;
      trap_clr  = 0;
      #1;
   endtask

   task automatic branch(input logic [2:0] f, input logic lt, input logic eq, input logic [31:0] t);
      idle();
      is_branch = 1;
      funct3    = f;
      br_less   = lt;
      br_equal  = eq;
      target    = t;
      #1;
   endtask

   task automatic jump(input bit jalr, input logic [31:0] t);
      idle();
      is_jal  = !jalr;
      is_jalr = jalr;
      target  = t;
      #1;
   endtask

   initial begin
      rst_n = 0;
      idle();
      step();
      step();
      chk_en = 1;
      rst_n  = 1;
      chk("reset_pc", pc, 32'h0);
      chk("reset_pc_four", pc_four, 32'h4);
      chk("reset_cnt", {16'd0, taken_cnt}, 32'd0);
      chk("reset_trap", {31'd0, trap}, 32'd0);

      // sequential fetch
      step(); chk("seq_pc4", pc, 32'h4);
      step(); chk("seq_pc8", pc, 32'h8);
      step(); chk("seq_pcc", pc, 32'hC);
      chk("seq_cnt", {16'd0, taken_cnt}, 32'd0);

      // BLT taken, then not taken
      branch(3'b100, 1, 0, 32'h40);
      chk("blt_br_un", {31'd0, br_un}, 32'd0);
      chk("blt_taken", {31'd0, taken}, 32'd1);
      step(); chk("blt_pc", pc, 32'h40);
      chk("blt_cnt", {16'd0, taken_cnt}, 32'd1);
      branch(3'b100, 0, 0, 32'h40);
      chk("blt_nt_taken", {31'd0, taken}, 32'd0);
      step(); chk("blt_nt_pc", pc, 32'h44);

      // BGEU with less=1 is not taken, and selects unsigned compare
      branch(3'b111, 1, 0, 32'h500);
      chk("bgeu_br_un", {31'd0, br_un}, 32'd1);
      chk("bgeu_taken", {31'd0, taken}, 32'd0);
      step(); chk("bgeu_pc", pc, 32'h48);

      // JALR clears bit 0; JAL to misaligned target traps
      jump(1, 32'h81);
      step(); chk("jalr_pc", pc, 32'h80);
      chk("jalr_cnt", {16'd0, taken_cnt}, 32'd2);
      jump(0, 32'h82);
      chk("jal_mis_taken", {31'd0, taken}, 32'd1);
      step(); chk("trap_pc", pc, 32'h100);
      chk("trap_flag", {31'd0, trap}, 32'd1);
      chk("trap_taken_low", {31'd0, taken}, 32'd0);
      chk("trap_cnt", {16'd0, taken_cnt}, 32'd2);

      // stall in trap, then clear
      idle(); stall = 1;
      step(); chk("trap_stall_pc1", pc, 32'h100);
      step(); chk("trap_stall_pc2", pc, 32'h100);
      stall = 0; trap_clr = 1;
      step(); chk("clr_trap", {31'd0, trap}, 32'd0);
      chk("clr_pc", pc, 32'h100);
      trap_clr = 0;
      step(); chk("after_clr_pc", pc, 32'h104);
      trap_clr = 1;
      step(); chk("clr_in_run_pc", pc, 32'h108);
      chk("clr_in_run_trap", {31'd0, trap}, 32'd0);

      // stalled taken BEQ holds, then proceeds
      branch(3'b000, 0, 1, 32'h300);
      stall = 1;
      step(); chk("stall_pc", pc, 32'h108);
      chk("stall_cnt", {16'd0, taken_cnt}, 32'd2);
      stall = 0;
      step(); chk("beq_pc", pc, 32'h300);
      chk("beq_cnt", {16'd0, taken_cnt}, 32'd3);

      // PC wrap
      jump(0, 32'hFFFF_FFFC);
      step(); chk("wrap_pre_pc", pc, 32'hFFFF_FFFC);
      chk("wrap_pc_four", pc_four, 32'h0);
      idle();
      step(); chk("wrap_pc", pc, 32'h0);
      chk("wrap_cnt", {16'd0, taken_cnt}, 32'd4);

      // BNE taken, funct3 010 never taken
      branch(3'b001, 0, 0, 32'h10);
      step(); chk("bne_pc", pc, 32'h10);
      branch(3'b010, 1, 1, 32'h600);
      chk("f3_010_taken", {31'd0, taken}, 32'd0);
      step(); chk("f3_010_pc", pc, 32'h14);

      // trap with cnt=5, then reset overriding stall and redirect
      jump(0, 32'h6);
      step(); chk("trap5_flag", {31'd0, trap}, 32'd1);
      chk("trap5_cnt", {16'd0, taken_cnt}, 32'd5);
      jump(0, 32'h40);
      stall = 1;
      rst_n = 0;
      step(); chk("rst_pc", pc, RESET_PC);
      chk("rst_trap", {31'd0, trap}, 32'd0);
      chk("rst_cnt", {16'd0, taken_cnt}, 32'd0);
      rst_n = 1;
      stall = 0;

      // saturation
      jump(0, 32'h20);
      for (int i = 0; i < 65536; i++) step();
      chk("sat_cnt", {16'd0, taken_cnt}, 32'h0000_FFFF);
      for (int i = 0; i < 3; i++) step();
      chk("sat_hold_cnt", {16'd0, taken_cnt}, 32'h0000_FFFF);
      chk("sat_pc", pc, 32'h20);

      idle();
      step();
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
